// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   STATS_WIDTH : width of each per-requester word counter
//   idx_width() : bits needed to index N requesters (minimum 1)
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int STATS_WIDTH = 16;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search over a request vector.
// Kept generic so a read-side scheduler can reuse it.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_owner in  IDX_W    index granted most recently
//   next_idx   out IDX_W    first set request strictly after last_owner (wrapping)
//   found      out 1        at least one request is set
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [IDX_W-1:0]   next_idx,
  output logic               found
);

  // Each candidate j gets a rotated distance from last_owner+1; the set
  // request with the smallest distance wins. last_owner itself ends up at
  // distance NUM_REQ-1, so it is only picked when it is the sole requester.
  always_comb begin
    int d;
    int best;
    next_idx = '0;
    found    = 1'b0;
    best     = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = j - int'(last_owner) - 1;
      if (d < 0) d = d + NUM_REQ;
      if (req[j] && (d < best)) begin
        best     = d;
        next_idx = IDX_W'(j);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ
// requesters, write-clock domain only. A grant lasts up to MAX_BURST words;
// every handover passes through IDLE, so bursts are separated by one cycle.
// Optional build macro FIFO_ARB_STATS_EN adds per-requester saturating
// 16-bit accepted-word counters on port word_count.
// Ports:
//   clk        in  1                   write-domain clock
//   rst        in  1                   asynchronous active-high reset
//   req        in  NUM_REQ             per-requester word pending
//   req_data   in  NUM_REQ*DATA_WIDTH  flattened words, slice i = requester i
//   full       in  1                   FIFO full (write-domain synchronised)
//   ack        out NUM_REQ             one-hot, word accepted this cycle
//   wr_en      out 1                   FIFO write enable
//   data_in    out DATA_WIDTH          FIFO write data (owner's slice)
//   grant_id   out clog2(NUM_REQ)      current owner index
//   busy       out 1                   high while in GRANT
//   word_count out NUM_REQ*16          (FIFO_ARB_STATS_EN only) accepted words
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [idx_width(NUM_REQ)-1:0] grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_WIDTH-1:0] word_count
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_t       state, state_n;
  logic [IDX_W-1:0] grant_n;
  logic [IDX_W-1:0] last_owner, last_n;
  logic [CNT_W-1:0] burst_cnt, cnt_n;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             owner_req;
  logic             burst_last;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req),
    .last_owner (last_owner),
    .next_idx   (pick_idx),
    .found      (pick_found)
  );

  // Owner request bit and data slice, selected by grant_id.
  always_comb begin
    owner_req = 1'b0;
    data_in   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_id == IDX_W'(j)) begin
        owner_req = req[j];
        data_in   = req_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // full is used combinationally so a write can never be issued into a full FIFO.
  always_comb begin
    busy  = (state == GRANT);
    wr_en = busy && owner_req && !full;
    ack   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      ack[j] = wr_en && (grant_id == IDX_W'(j));
    end
  end

  assign burst_last = (burst_cnt == CNT_W'(MAX_BURST - 1));

  always_comb begin
    state_n = state;
    grant_n = grant_id;
    last_n  = last_owner;
    cnt_n   = burst_cnt;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          grant_n = pick_idx;
          last_n  = pick_idx;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        // A dropped request forfeits the grant; a stall on full just waits.
        if (!owner_req) begin
          state_n = IDLE;
        end else if (wr_en) begin
          cnt_n = burst_cnt + 1'b1;
          if (burst_last) state_n = IDLE;
        end
      end
    endcase
  end

  // last_owner resets to the top index so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_n;
      grant_id   <= grant_n;
      last_owner <= last_n;
      burst_cnt  <= cnt_n;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] v);
    return (v == {STATS_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    logic [STATS_WIDTH-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (ack[g]) begin
        cnt <= sat_inc(cnt);
      end
    end
    assign word_count[g*STATS_WIDTH +: STATS_WIDTH] = cnt;
  end
`endif

endmodule
